seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed driver for N common-anode 7-segment digits sharing one segment bus.
//   - Latches a packed BCD/hex word plus per-digit decimal points.
//   - Scans the digits at a programmable rate.
//   - Swaps in new data only at frame boundaries, so no torn display.
//   - Sits between the clock/counter datapath and the board pins; replaces per-digit static decoders.
// PARAMETERS
//   N_DIGITS     4     number of digits scanned, >=2
//   REFRESH_DIV  1000  clk cycles each digit is selected, >=4
//   HEX_MODE     0     1: codes 10-15 show A b C d E F; 0: codes 10-15 show "0" (8'hC0)
// PORTS
//   clk         in   1           system clock
//   rst         in   1           synchronous, active-high reset
//   en          in   1           1 = scanning; 0 = display dark, scan frozen
//   load        in   1           1-cycle strobe: capture digits_in/dp_in into pending register
//   digits_in   in   4*N_DIGITS  nibble k = digit k (k=0 rightmost)
//   dp_in       in   N_DIGITS    bit k = 1 lights decimal point of digit k
//   seg         out  8           active-low {dp,g,f,e,d,c,b,a}
//   an          out  N_DIGITS    active-low digit select, one-hot-low when lit
//   frame_tick  out  1           1-cycle pulse when the scan wraps to digit 0
// BEHAVIOUR
//   Reset: seg=8'hFF, an=all 1, frame_tick=0, prescaler=0, idx=0, display reg=0, pending reg=0, pend_v=0.
//   Prescaler counts 0..REFRESH_DIV-1 while en=1. At terminal count:
//     - it returns to 0;
//     - idx advances by 1, wrapping from N_DIGITS-1 to 0.
//   Wrap event (terminal count with idx=N_DIGITS-1):
//     - frame_tick=1 on the next cycle;
//     - if pend_v=1: display <= pending, pend_v cleared.
//   load=1: pending <= {digits_in,dp_in}, pend_v <= 1. Works regardless of en.
//   load coincident with a wrap:
//     - display takes the OLD pending value;
//     - new data goes into pending;
//     - pend_v stays 1, so the new data is shown at the next wrap.
//   Anti-ghosting: on the cycle idx changes (prescaler==0), an=all 1.
//     From the following cycle: an[idx]=0, all other an bits 1.
//   Outputs are registered, 1-cycle latency from idx/display state:
//     seg = {~dp[idx], code(display nibble idx)[6:0]}.
//   Decode table (active low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 98.
//     10-15 with HEX_MODE=1: 88 83 C6 A1 86 8E.
//     10-15 with HEX_MODE=0: C0.
//   en=0:
//     - seg=8'hFF and an=all 1 on the next cycle;
//     - prescaler and idx hold;
//     - frame_tick=0.
//     en rising resumes from the held idx/prescaler.
//   rst mid-frame: all state returns to reset values on the next edge; pending data is discarded.
// CONFIGURATION
//   Macro LEADING_ZERO_BLANK_EN.
//   Defined:
//     - digit k>0 is blank when every nibble j>=k of display equals 0;
//     - a blank digit drives seg={~dp[k],7'h7F};
//     - digit 0 is never blanked;
//     - an timing is unchanged.
//   Undefined: every digit is decoded; the blanking logic is not compiled.
// STRUCTURE
//   Package seg7_pkg:
//     - SEG_OFF=8'hFF;
//     - digit-code constants SEG_0..SEG_9, SEG_A..SEG_F.
//   Sub-module seg7_decode (combinational, param HEX_MODE): nibble -> 7 active-low segment bits.
//   Top holds the prescaler, idx counter, pending/display registers, output registers and blank mask.
// TESTING
//   N_DIGITS=4, REFRESH_DIV=4 unless noted.
//   T1 reset:
//     - hold rst 3 cycles -> seg=FF, an=F, frame_tick=0;
//     - first lit state after release: an=E, seg=C0 (display=0).
//   T2 scan:
//     - load digits_in=16'h1234, dp_in=4'b0100;
//     - after the first frame_tick: digit0 seg=99, digit1 seg=B0, digit2 seg=24 (dp lit), digit3 seg=F9;
//     - each digit selected 3 cycles plus 1 blank cycle.
//   T3 tear-free:
//     - load 16'h5555 mid-frame -> an/seg keep the old value until the wrap;
//     - first digit0 after frame_tick shows 92.
//   T4 simultaneous:
//     - load A coincident with a wrap, pend_v=1 holding B -> B is shown this frame, A the next frame.
//   T5 en/hex:
//     - en=0 for 20 cycles -> seg=FF, an=F, no frame_tick; scan resumes at the held idx;
//     - HEX_MODE=1, nibble 4'hB -> 83; HEX_MODE=0 -> C0.
//   T6 LEADING_ZERO_BLANK_EN:
//     - load 16'h0070 -> digits 3 and 2 show FF;
//     - digit1 shows F8, digit0 shows C0;
//     - load 16'h0000 -> only digit0 shows C0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low glyph codes {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h98;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble -> active-low segment decoder; HEX_MODE=0 renders 10-15 as "0".
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_0[6:0];
    case (nibble_i)
      4'h0: seg_o = SEG_0[6:0];
      4'h1: seg_o = SEG_1[6:0];
      4'h2: seg_o = SEG_2[6:0];
      4'h3: seg_o = SEG_3[6:0];
      4'h4: seg_o = SEG_4[6:0];
      4'h5: seg_o = SEG_5[6:0];
      4'h6: seg_o = SEG_6[6:0];
      4'h7: seg_o = SEG_7[6:0];
      4'h8: seg_o = SEG_8[6:0];
      4'h9: seg_o = SEG_9[6:0];
      4'hA: seg_o = (HEX_MODE != 0) ? SEG_A[6:0] : SEG_0[6:0];
      4'hB: seg_o = (HEX_MODE != 0) ? SEG_B[6:0] : SEG_0[6:0];
      4'hC: seg_o = (HEX_MODE != 0) ? SEG_C[6:0] : SEG_0[6:0];
      4'hD: seg_o = (HEX_MODE != 0) ? SEG_D[6:0] : SEG_0[6:0];
      4'hE: seg_o = (HEX_MODE != 0) ? SEG_E[6:0] : SEG_0[6:0];
      4'hF: seg_o = (HEX_MODE != 0) ? SEG_F[6:0] : SEG_0[6:0];
      default: seg_o = SEG_0[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned data swap.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int HEX_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int PSC_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PSC_W-1:0]      psc_q, psc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] disp_dig_q, disp_dig_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*N_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pend_v_q, pend_v_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  ft_q, ft_d;

  logic       psc_tc;
  logic       wrap;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic [6:0] cur_code;
  logic [6:0] code7;

  assign psc_tc  = en && (psc_q == PSC_LAST);
  assign wrap    = psc_tc && (idx_q == IDX_LAST);
  assign cur_nib = disp_dig_q[{idx_q, 2'b00} +: 4];
  assign cur_dp  = disp_dp_q[idx_q];

  seg7_decode #(.HEX_MODE(HEX_MODE)) u_decode (
    .nibble_i (cur_nib),
    .seg_o    (cur_code)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more-significant nibble are zero; digit 0 never blanks.
  logic [N_DIGITS-1:0] blank_mask;

  always_comb begin : blank_scan
    logic zero_run;
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run && (disp_dig_q[4*k +: 4] == 4'h0);
      blank_mask[k] = zero_run;
    end
  end

  assign code7 = blank_mask[idx_q] ? 7'h7F : cur_code;
`else
  assign code7 = cur_code;
`endif

  always_comb begin
    psc_d      = psc_q;
    idx_d      = idx_q;
    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    seg_d      = SEG_OFF;
    an_d       = '1;
    ft_d       = 1'b0;

    if (en) begin
      if (psc_tc) begin
        psc_d = '0;
        idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
      seg_d = {~cur_dp, code7};
      // Anodes stay dark for the first cycle of each digit slot to avoid ghosting.
      if (psc_q != '0) begin
        an_d[idx_q] = 1'b0;
      end
      ft_d = wrap;
      if (wrap && pend_v_q) begin
        disp_dig_d = pend_dig_q;
        disp_dp_d  = pend_dp_q;
        pend_v_d   = 1'b0;
      end
    end

    // A load coincident with a wrap lands in pending after the old pending moved to display.
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q      <= '0;
      idx_q      <= '0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_v_q   <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= '1;
      ft_q       <= 1'b0;
    end else begin
      psc_q      <= psc_d;
      idx_q      <= idx_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q  <= disp_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_v_q   <= pend_v_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      ft_q       <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule
